carry_lookahead_adder: RTL and testbench

- Registered carry-lookahead adder: S/Cout = a + b + cin, with carries computed by two-level lookahead.
- First level: 4-bit groups. Second level: across groups. No ripple between groups.
- Arithmetic leaf for datapaths that need a fixed one-cycle adder with a valid qualifier.

---
 rtl/carrylook_pkg.sv | 17 +
 rtl/cla_group4.sv | 33 +++
 rtl/carry_lookahead_adder.sv | 116 +++++++++++
 tb/tb_carry_lookahead_adder.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/carrylook_pkg.sv
// Shared constants, types and helpers for the two-level carry-lookahead adder.
package carrylook_pkg;

  localparam int unsigned GRP_W = 4;
  localparam int unsigned MAX_W = 64;

  // Group-level generate/propagate pair
  typedef struct packed {
    logic g;
    logic p;
  } pg_t;

  function automatic int unsigned num_groups(input int unsigned width);
    return width / GRP_W;
  endfunction

endpackage

// File: rtl/cla_group4.sv
// Combinational 4-bit lookahead unit: internal carries plus group generate/propagate.
module cla_group4
  import carrylook_pkg::*;
(
  input  logic [GRP_W-1:0] g,
  input  logic [GRP_W-1:0] p,
  input  logic             ci,
  output logic [GRP_W-1:1] c,
  output logic             G,
  output logic             P
);

  // Each carry is a flat sum of products of g, p and ci
  assign c[1] = g[0]
              | (p[0] & ci);

  assign c[2] = g[1]
              | (p[1] & g[0])
              | (p[1] & p[0] & ci);

  assign c[3] = g[2]
              | (p[2] & g[1])
              | (p[2] & p[1] & g[0])
              | (p[2] & p[1] & p[0] & ci);

  assign G    = g[3]
              | (p[3] & g[2])
              | (p[3] & p[2] & g[1])
              | (p[3] & p[2] & p[1] & g[0]);

  assign P    = p[0] & p[1] & p[2] & p[3];

endmodule

// File: rtl/carry_lookahead_adder.sv
// Registered two-level carry-lookahead adder with valid qualifier.
// Define CARRYLOOK_OVF_EN to add the registered signed-overflow output ovf.
module carry_lookahead_adder
  import carrylook_pkg::*;
#(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] S,
  output logic             Cout,
`ifdef CARRYLOOK_OVF_EN
  output logic             ovf,
`endif
  output logic             out_valid
);

  localparam int unsigned NG = num_groups(WIDTH);

  if ((WIDTH == 0) || ((WIDTH % GRP_W) != 0) || (WIDTH > MAX_W)) begin : g_bad_width
    $error("carry_lookahead_adder: WIDTH must be a positive multiple of 4, at most 64");
  end

  logic [WIDTH-1:0] w_g;
  logic [WIDTH-1:0] w_p;
  logic [WIDTH:0]   w_c;
  pg_t  [NG-1:0]    w_grp;
  logic [NG:0]      w_gx;
  logic [NG:0]      w_px;
  logic [NG:0]      w_gci;

  logic [WIDTH-1:0] r_sum;
  logic             r_cout;
  logic             r_valid;

  assign w_g = a & b;
  assign w_p = a ^ b;

  // First level: one lookahead unit per 4-bit group
  for (genvar k = 0; k < NG; k++) begin : g_grp
    cla_group4 u_grp (
      .g  (w_g[k*GRP_W +: GRP_W]),
      .p  (w_p[k*GRP_W +: GRP_W]),
      .ci (w_gci[k]),
      .c  (w_c[k*GRP_W+1 +: GRP_W-1]),
      .G  (w_grp[k].g),
      .P  (w_grp[k].p)
    );
    assign w_c[k*GRP_W] = w_gci[k];
    assign w_gx[k+1]    = w_grp[k].g;
    assign w_px[k+1]    = w_grp[k].p;
  end

  // cin acts as the generate of a virtual group below group 0
  assign w_gx[0] = cin;
  assign w_px[0] = 1'b0;
  assign w_c[WIDTH] = w_gci[NG];

  // Second level: carry into group k = OR_j gx[j] & px[j+1..k], all terms in parallel
  always_comb begin : second_level
    logic w_term;
    logic w_sop;
    w_gci  = '0;
    w_term = 1'b0;
    w_sop  = 1'b0;
    w_gci[0] = cin;
    for (int k = 1; k <= int'(NG); k++) begin
      w_sop = 1'b0;
      for (int j = 0; j < k; j++) begin
        w_term = w_gx[j];
        for (int m = j + 1; m < k; m++) begin
          w_term = w_term & w_px[m];
        end
        w_sop = w_sop | (w_term & w_px[k] ) | (j == k - 1 ? w_gx[k] : 1'b0);
      end
      w_gci[k] = w_sop;
    end
  end

`ifdef CARRYLOOK_OVF_EN
  logic r_ovf;
`endif

  // Output registers; idle cycles hold the last result
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_sum   <= '0;
      r_cout  <= 1'b0;
      r_valid <= 1'b0;
`ifdef CARRYLOOK_OVF_EN
      r_ovf   <= 1'b0;
`endif
    end else begin
      r_valid <= in_valid;
      if (in_valid) begin
        r_sum  <= w_p ^ w_c[WIDTH-1:0];
        r_cout <= w_c[WIDTH];
`ifdef CARRYLOOK_OVF_EN
        r_ovf  <= w_c[WIDTH] ^ w_c[WIDTH-1];
`endif
      end
    end
  end

  assign S         = r_sum;
  assign Cout      = r_cout;
  assign out_valid = r_valid;
`ifdef CARRYLOOK_OVF_EN
  assign ovf       = r_ovf;
`endif

endmodule

// File: tb/tb_carry_lookahead_adder.sv
// Scoreboard bench for carry_lookahead_adder at WIDTH=4 and WIDTH=16.
module tb_carry_lookahead_adder;

  typedef struct packed {
    logic        v;
    logic        c;
    logic        o;
    logic [15:0] s;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        v4, c4, v16, c16;
  logic [3:0]  a4, b4;
  logic [15:0] a16, b16;
  logic [3:0]  s4;
  logic [15:0] s16;
  logic        co4, co16, ov4, ov16;
  logic        of4, of16;

  exp_t q4[$];
  exp_t q16[$];
  exp_t m4, m16;
  int   n_checks = 0;
  int   n_pass   = 0;

  carry_lookahead_adder #(.WIDTH(4)) dut4 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (v4),
    .a         (a4),
    .b         (b4),
    .cin       (c4),
    .S         (s4),
    .Cout      (co4),
`ifdef CARRYLOOK_OVF_EN
    .ovf       (of4),
`endif
    .out_valid (ov4)
  );

  carry_lookahead_adder #(.WIDTH(16)) dut16 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (v16),
    .a         (a16),
    .b         (b16),
    .cin       (c16),
    .S         (s16),
    .Cout      (co16),
`ifdef CARRYLOOK_OVF_EN
    .ovf       (of16),
`endif
    .out_valid (ov16)
  );

`ifndef CARRYLOOK_OVF_EN
  assign of4  = 1'b0;
  assign of16 = 1'b0;
`endif

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Reference model of what should be visible after the next edge
  task automatic cycle();
    logic [4:0]  r5;
    logic [16:0] r17;
    exp_t e;
    if (!rst_n) begin
      m4  = '0;
      m16 = '0;
    end else begin
      m4.v  = v4;
      m16.v = v16;
      if (v4) begin
        r5   = {1'b0, a4} + {1'b0, b4} + 5'(c4);
        m4.s = 16'(r5[3:0]);
        m4.c = r5[4];
        m4.o = (a4[3] == b4[3]) && (r5[3] != a4[3]);
      end
      if (v16) begin
        r17   = {1'b0, a16} + {1'b0, b16} + 17'(c16);
        m16.s = r17[15:0];
        m16.c = r17[16];
        m16.o = (a16[15] == b16[15]) && (r17[15] != a16[15]);
      end
    end
    q4.push_back(m4);
    q16.push_back(m16);
    @(posedge clk);
    #1;
    if (q4.size() == 0) check("q4_empty", 32'd1, 32'd0);
    else begin
      e = q4.pop_front();
      check("w4_valid", 32'(ov4), 32'(e.v));
      check("w4_sum",   32'(s4),  32'(e.s));
      check("w4_cout",  32'(co4), 32'(e.c));
`ifdef CARRYLOOK_OVF_EN
      check("w4_ovf",   32'(of4), 32'(e.o));
`endif
    end
    if (q16.size() == 0) check("q16_empty", 32'd1, 32'd0);
    else begin
      e = q16.pop_front();
      check("w16_valid", 32'(ov16), 32'(e.v));
      check("w16_sum",   32'(s16),  32'(e.s));
      check("w16_cout",  32'(co16), 32'(e.c));
`ifdef CARRYLOOK_OVF_EN
      check("w16_ovf",   32'(of16), 32'(e.o));
`endif
    end
  endtask

  task automatic drive4(input logic v, input logic [3:0] a, input logic [3:0] b, input logic c);
    v4 = v; a4 = a; b4 = b; c4 = c;
    cycle();
  endtask

  task automatic drive16(input logic [15:0] a, input logic [15:0] b, input logic c);
    v16 = 1'b1; a16 = a; b16 = b; c16 = c;
    cycle();
  endtask

  initial begin
    m4 = '0; m16 = '0;
    rst_n = 1'b0;
    v16 = 1'b1; a16 = 16'hFFFF; b16 = 16'hFFFF; c16 = 1'b1;
    // Reset wins over a valid input
    drive4(1'b1, 4'hF, 4'hF, 1'b1);
    drive4(1'b1, 4'hF, 4'hF, 1'b1);
    rst_n = 1'b1;
    v16 = 1'b0;
    drive4(1'b1, 4'h1, 4'h3, 1'b0);
    drive4(1'b1, 4'h3, 4'hC, 1'b0);
    drive4(1'b1, 4'h9, 4'h9, 1'b0);
    drive4(1'b1, 4'hF, 4'h0, 1'b1);
    drive4(1'b1, 4'h0, 4'h0, 1'b0);
    drive4(1'b1, 4'h5, 4'h5, 1'b0);
    for (int i = 0; i < 3; i++) drive4(1'b0, 4'hF, 4'hF, 1'b1);
    drive4(1'b1, 4'h2, 4'h3, 1'b0);
    rst_n = 1'b0;
    drive4(1'b1, 4'h7, 4'h7, 1'b0);
    rst_n = 1'b1;
    drive4(1'b1, 4'h6, 4'h1, 1'b1);
    drive4(1'b1, 4'h7, 4'h1, 1'b0);
    v4 = 1'b0;
    // Wide corners, then random traffic on both widths
    drive16(16'hFFFF, 16'h0000, 1'b1);
    drive16(16'h7FFF, 16'h0001, 1'b0);
    drive16(16'h8000, 16'h8000, 1'b0);
    drive16(16'hFFFF, 16'hFFFF, 1'b1);
    drive16(16'h0000, 16'h0000, 1'b0);
    drive16(16'h0FFF, 16'h0001, 1'b0);
    for (int i = 0; i < 10000; i++) begin
      v4  = ($urandom_range(7) != 0);
      a4  = 4'($urandom);
      b4  = 4'($urandom);
      c4  = 1'($urandom);
      v16 = ($urandom_range(7) != 0);
      a16 = 16'($urandom);
      b16 = 16'($urandom);
      c16 = 1'($urandom);
      cycle();
    end
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
